adder_seq: RTL and testbench
============================

Name: adder_seq

Overview:
- Parametrised, multi-cycle, digit-serial two's-complement adder/subtractor. It is the next generation of the fixed-width combinational ripple adder.
- Processes DIGIT bits per clock from LSB to MSB. A carry register links the digits.
- Uses valid/ready handshakes on both the operand side and the result side. This lets wide additions share a small adder in the datapath units.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of DIGIT, and WIDTH >= 2.
- DIGIT, 4, bits added per cycle. Must satisfy 1 <= DIGIT <= WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands are valid.
- in_ready  out  1  block accepts operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = A-B, 0 = A+B.
- cin  in  1  carry-in, used only when sub=0.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum or difference.
- cout  out  1  carry out of the MSB. In subtract mode 1 means no borrow.
- ovfl  out  1  signed overflow, = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE
  - in_ready=1, out_valid=0
  - s=0, cout=0, ovfl=0
  - digit counter=0, carry register=0
- Reset overrides every other input, including when it is asserted mid-RUN or in DONE. The in-flight operation is discarded and no result is produced.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, latch a, b^{WIDTH{sub}}, and carry = sub ? 1 : cin. Clear the counter and go to RUN.
  - RUN: in_ready=0. Each cycle, the digit slice [k*DIGIT +: DIGIT] is added with the carry register. The result is written into the same slice of s, the carry is updated, and k increments. After the last digit (k = WIDTH/DIGIT-1), register cout and ovfl and go to DONE.
  - DONE: out_valid=1. s, cout and ovfl are held stable while out_valid=1 & out_ready=0. On out_ready=1, go to IDLE with out_valid=0 on the next cycle.
- Latency: WIDTH/DIGIT cycles from the accept edge to out_valid=1.
  - Throughput is one operation per WIDTH/DIGIT+2 cycles.
  - A new accept cannot occur in the same cycle as the result handshake.
- Operands presented while in_ready=0 are ignored and not queued. a, b, sub and cin may change freely after the accept.
- ovfl: carry into the MSB is taken from the last digit's internal carry at bit WIDTH-2→WIDTH-1.
- DIGIT=WIDTH degenerates to single-cycle RUN (latency 1).
- Contents of s during RUN are internal and not valid. Only out_valid qualifies s.

Optional Feature:
- Macro: ADDER_SEQ_SATURATE_EN.
- Defined: when ovfl=1 in DONE, s is replaced by a signed saturated value.
  - 0111…1 when the true result is positive, i.e. operand A MSB=0.
  - 1000…0 when it is negative.
  - ovfl still reports 1. cout is unchanged.
  - Saturation is applied at the RUN→DONE transition and adds no cycle.
- Not defined: s is the wrapped modulo-2^WIDTH result. No saturation logic is present.

Decomposition:
- Package adder_seq_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - the counter-width function clog2(WIDTH/DIGIT).
- Sub-module digit_adder (parameter DIGIT): combinational DIGIT-bit ripple of full adders with ports s, co, c_msb_in, a, b, ci. It exposes the carry into its top bit for overflow detection.
- The FSM, operand shift/slice registers and result register live in adder_seq.

Test Plan:
- WIDTH=16, DIGIT=4: a=0x7FFF, b=0x0001, sub=0, cin=0 -> out_valid exactly 4 cycles after accept; s=0x8000, cout=0, ovfl=1. With ADDER_SEQ_SATURATE_EN: s=0x7FFF, ovfl=1.
- a=0xFFFF, b=0x0001, sub=0, cin=0 -> s=0x0000, cout=1, ovfl=0. Also a=0x1234, b=0x0000, cin=1 -> s=0x1235.
- sub=1, a=0x0005, b=0x0007 (cin=1, ignored) -> s=0xFFFE, cout=0, ovfl=0. Also a=0x8000, b=0x0001 -> s=0x7FFF, ovfl=1, saturated build s=0x8000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> s/cout/ovfl stable, in_ready=0. Pulse in_valid with other operands during that time -> ignored. out_ready=1 -> IDLE next cycle.
- Reset mid-RUN: assert rst 2 cycles after accept -> next cycle in_ready=1, out_valid=0, s=0. The following operation 0x0003+0x0004 -> s=0x0007.
- Parameter sweep: DIGIT=1, 8 and 16 with WIDTH=16, plus WIDTH=32/DIGIT=8 -> latency WIDTH/DIGIT. Random operands checked against the reference model {cout,s} = a + (sub?~b:b) + (sub?1:cin).

Source files
------------

// File: rtl/adder_seq_pkg.sv
// -----------------------------------------------------------------------------
// adder_seq_pkg
// Shared definitions for the digit-serial adder/subtractor:
//   - state_t : FSM state encoding (ST_IDLE=0, ST_RUN=1, ST_DONE=2)
//   - clog2() : ceiling log2, used to size the digit counter
// -----------------------------------------------------------------------------
package adder_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0, so callers needing a non-empty counter
  // must clamp the result to at least 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_seq_digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Combinational DIGIT-bit ripple of full adders.
// Ports:
//   a, b      in  DIGIT  operand digits
//   ci        in  1      carry into bit 0
//   s         out DIGIT  sum digit
//   co        out 1      carry out of the top bit
//   c_msb_in  out 1      carry into the top bit (for signed overflow)
// -----------------------------------------------------------------------------
import adder_seq_pkg::*;

module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // A local running carry keeps the chain inside one process, so the
  // ripple does not form a self-referencing vector.
  always_comb begin
    logic w_c;
    w_c      = ci;
    c_msb_in = ci;
    s        = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) begin
        c_msb_in = w_c;
      end
      s[i] = a[i] ^ b[i] ^ w_c;
      w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    co = w_c;
  end

endmodule

// File: rtl/adder_seq.sv
// -----------------------------------------------------------------------------
// adder_seq
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes.
// Adds DIGIT bits per clock, LSB first; latency WIDTH/DIGIT cycles from the
// accept edge to out_valid.
// Parameters: WIDTH (multiple of DIGIT, >= 2), DIGIT (1..WIDTH).
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  operand handshake
//   a, b                 operands (WIDTH)
//   sub                  1 = a-b, 0 = a+b
//   cin                  carry-in, addition only
//   out_valid/out_ready  result handshake
//   s                    sum/difference (WIDTH)
//   cout                 carry out of MSB (subtract: 1 = no borrow)
//   ovfl                 signed overflow
// Build option: define ADDER_SEQ_SATURATE_EN to saturate s on signed overflow.
// -----------------------------------------------------------------------------
import adder_seq_pkg::*;

module adder_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovfl
);

  localparam int N_DIG = WIDTH / DIGIT;
  localparam int CNT_W = (clog2(N_DIG) > 0) ? clog2(N_DIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(N_DIG - 1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovfl;

`ifdef ADDER_SEQ_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  // Sign of operand A decides the saturation direction; the operand
  // register itself is shifted away during RUN.
  logic             r_a_msb;
`endif

  logic [DIGIT-1:0] w_sum;
  logic             w_co;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_s_next;

  // Operands are shifted right each RUN cycle, so the active digit is
  // always the low slice.
  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a        (r_a[DIGIT-1:0]),
    .b        (r_b[DIGIT-1:0]),
    .ci       (r_carry),
    .s        (w_sum),
    .co       (w_co),
    .c_msb_in (w_c_msb)
  );

  // The result fills from the top: after N_DIG shifts the first digit
  // computed has landed in the LSB slice.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign w_s_next = w_sum;
    end else begin : g_multi
      assign w_s_next = {w_sum, r_s[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ovfl      <= 1'b0;
`ifdef ADDER_SEQ_SATURATE_EN
      r_a_msb     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b ^ {WIDTH{sub}};
            r_carry    <= sub | cin;  // subtract = a + ~b + 1
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
`ifdef ADDER_SEQ_SATURATE_EN
            r_a_msb    <= a[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_DIG) begin
            r_cout      <= w_co;
            r_ovfl      <= w_co ^ w_c_msb;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
`ifdef ADDER_SEQ_SATURATE_EN
            if (w_co ^ w_c_msb) begin
              r_s <= r_a_msb ? SAT_NEG : SAT_POS;
            end else begin
              r_s <= w_s_next;
            end
`else
            r_s <= w_s_next;
`endif
          end else begin
            r_s <= w_s_next;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovfl      = r_ovfl;

endmodule

// File: tb/tb_adder_seq.sv
// -----------------------------------------------------------------------------
// tb_adder_seq
// Drives five adder_seq instances (16/4, 16/1, 16/8, 16/16, 32/8) with shared
// operands and checks latency and results against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_adder_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic [4:0]  in_ready_v;
  logic [4:0]  out_valid_v;
  logic [4:0]  cout_v;
  logic [4:0]  ovfl_v;
  logic [15:0] s0, s1, s2, s3;
  logic [31:0] s4;
  logic [31:0] s_arr [5];

  always_comb begin
    s_arr[0] = {16'h0, s0};
    s_arr[1] = {16'h0, s1};
    s_arr[2] = {16'h0, s2};
    s_arr[3] = {16'h0, s3};
    s_arr[4] = s4;
  end

  localparam int W_TAB   [5] = '{16, 16, 16, 16, 32};
  localparam int LAT_TAB [5] = '{4, 16, 2, 1, 4};

  adder_seq #(.WIDTH(16), .DIGIT(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .a(a[15:0]), .b(b[15:0]), .sub(sub), .cin(cin),
    .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .s(s0), .cout(cout_v[0]), .ovfl(ovfl_v[0]));
  adder_seq #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .a(a[15:0]), .b(b[15:0]), .sub(sub), .cin(cin),
    .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .s(s1), .cout(cout_v[1]), .ovfl(ovfl_v[1]));
  adder_seq #(.WIDTH(16), .DIGIT(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .a(a[15:0]), .b(b[15:0]), .sub(sub), .cin(cin),
    .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .s(s2), .cout(cout_v[2]), .ovfl(ovfl_v[2]));
  adder_seq #(.WIDTH(16), .DIGIT(16)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[3]),
    .a(a[15:0]), .b(b[15:0]), .sub(sub), .cin(cin),
    .out_valid(out_valid_v[3]), .out_ready(out_ready),
    .s(s3), .cout(cout_v[3]), .ovfl(ovfl_v[3]));
  adder_seq #(.WIDTH(32), .DIGIT(8)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[4]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid_v[4]), .out_ready(out_ready),
    .s(s4), .cout(cout_v[4]), .ovfl(ovfl_v[4]));

  int checks = 0;
  int errors = 0;

  logic [31:0] got_s   [5];
  logic        got_c   [5];
  logic        got_v   [5];
  int          got_lat [5];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: returns {ovfl, cout, s[31:0]} for a w-bit adder.
  function automatic logic [33:0] model(input int w, input logic [31:0] ma,
                                        input logic [31:0] mb, input logic msub,
                                        input logic mcin);
    logic [31:0] mask, am, bo, sm;
    logic [32:0] full;
    logic        co, ov, amsb, bmsb, smsb;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am   = ma & mask;
    bo   = (msub ? ~mb : mb) & mask;
    full = {1'b0, am} + {1'b0, bo} + {32'd0, (msub ? 1'b1 : mcin)};
    sm   = full[31:0] & mask;
    co   = full[w];
    amsb = am[w-1];
    bmsb = bo[w-1];
    smsb = sm[w-1];
    ov   = (amsb == bmsb) && (smsb != amsb);
`ifdef ADDER_SEQ_SATURATE_EN
    if (ov) sm = amsb ? (32'd1 << (w - 1)) : (mask >> 1);
`endif
    return {ov, co, sm};
  endfunction

  // One operation with out_ready held high; checks all five instances.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tsub, input logic tcin);
    logic [33:0] e;
    bit          all_done;
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready_v), 64'h1f);
    a = ta; b = tb_; sub = tsub; cin = tcin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Operands may change freely once accepted.
    a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    for (int i = 0; i < 5; i++) begin
      got_lat[i] = 0; got_s[i] = 'x; got_c[i] = 1'bx; got_v[i] = 1'bx;
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      all_done = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (out_valid_v[i] && got_lat[i] == 0) begin
          got_lat[i] = cyc; got_s[i] = s_arr[i];
          got_c[i] = cout_v[i]; got_v[i] = ovfl_v[i];
        end
        if (got_lat[i] == 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
    for (int i = 0; i < 5; i++) begin
      e = model(W_TAB[i], ta, tb_, tsub, tcin);
      chk($sformatf("latency_dut%0d", i), 64'(got_lat[i]), 64'(LAT_TAB[i]));
      chk($sformatf("s_dut%0d", i),       64'(got_s[i]),   64'(e[31:0]));
      chk($sformatf("cout_dut%0d", i),    64'(got_c[i]),   64'(e[32]));
      chk($sformatf("ovfl_dut%0d", i),    64'(got_v[i]),   64'(e[33]));
    end
    $display("op a=%08h b=%08h sub=%0d cin=%0d -> dut0 s=%04h cout=%0d ovfl=%0d lat=%0d",
             ta, tb_, tsub, tcin, got_s[0][15:0], got_c[0], got_v[0], got_lat[0]);
    @(posedge clk);  // result handshake edge of the slowest instance
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        sub, cin;
    logic [15:0] s;
    logic        c, v;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] e;
    int          seen;

`ifdef ADDER_SEQ_SATURATE_EN
    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
`endif
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1235, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready_v),  64'h1f);
    chk("rst_out_valid", 64'(out_valid_v), 64'h0);
    chk("rst_s0",        64'(s0),          64'h0);
    chk("rst_s4",        64'(s4),          64'h0);
    chk("rst_cout",      64'(cout_v),      64'h0);
    chk("rst_ovfl",      64'(ovfl_v),      64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed 16-bit results
    for (int k = 0; k < 5; k++) begin
      run_op({16'h0, vecs[k].a}, {16'h0, vecs[k].b}, vecs[k].sub, vecs[k].cin);
      chk($sformatf("dir%0d_s", k),    64'(got_s[0][15:0]), 64'(vecs[k].s));
      chk($sformatf("dir%0d_cout", k), 64'(got_c[0]),       64'(vecs[k].c));
      chk($sformatf("dir%0d_ovfl", k), 64'(got_v[0]),       64'(vecs[k].v));
    end

    // Backpressure: result held in DONE, new operands ignored
    out_ready = 1'b0;
    @(negedge clk);
    a = 32'h0000_7FFF; b = 32'h0000_0001; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    e = model(16, 32'h7FFF, 32'h1, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'(c & 1);
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      chk("bp_s0",        64'(s0),          64'(e[15:0]));
      chk("bp_cout0",     64'(cout_v[0]),   64'(e[32]));
      chk("bp_ovfl0",     64'(ovfl_v[0]),   64'(e[33]));
      chk("bp_out_valid", 64'(out_valid_v), 64'h1f);
      chk("bp_in_ready",  64'(in_ready_v),  64'h0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 64'(out_valid_v), 64'h0);
    chk("bp_release_in_ready",  64'(in_ready_v),  64'h1f);
    $display("op backpressure a=00007fff b=00000001 held 10 cycles, released");

    // Reset two cycles after accept discards the operation
    @(negedge clk);
    a = 32'h0000_1111; b = 32'h0000_2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready",  64'(in_ready_v),  64'h1f);
    chk("midrst_out_valid", 64'(out_valid_v), 64'h0);
    chk("midrst_s0",        64'(s0),          64'h0);
    chk("midrst_s4",        64'(s4),          64'h0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid_v != 5'h0) seen++;
    end
    chk("midrst_no_result", 64'(seen), 64'h0);
    $display("op reset mid-RUN a=00001111 b=00002222 discarded");
    run_op(32'h3, 32'h4, 1'b0, 1'b0);
    chk("post_rst_s0", 64'(got_s[0][15:0]), 64'h0007);

    // Random operands against the model
    for (int k = 0; k < 40; k++) begin
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
